safe_mode_sequencer: RTL and testbench

//  Sequences the switch between single-core and redundant execution of the 3-core safe wrapper.
//  - Triggered by the rising edge of the start bit from the safe wrapper control registers.
//  - Parks all cores at their sync point via debug request, then applies the new lockstep config.
//  - Wakes the participating cores and signals end of the routine back to the register block.
//  - Sits between the control register block and the core/voter cluster.

---
 rtl/safe_mode_sequencer.sv | 147 ++++++++++++++
 tb/tb_safe_mode_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/safe_mode_sequencer.sv
// Sequences the switch between single-core and redundant (DMR/TMR) execution:
// park all cores, apply the new lockstep configuration, wake the active cores.
module safe_mode_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WAKE_CYCLES    = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       safe_mode_i,
  input  logic [1:0] safe_configuration_i,
  input  logic [2:0] master_core_i,
  input  logic [2:0] core_sleep_i,
  output logic [2:0] debug_req_o,
  output logic [2:0] wake_o,
  output logic [2:0] active_cores_o,
  output logic [1:0] vote_mode_o,
  output logic       busy_o,
  output logic       end_routine_o,
  output logic       error_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] HALT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HALT    = 3'd1,
    S_SWITCH  = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;
  logic             r_mode;
  logic             r_dmr;
  logic [2:0]       r_master;
  logic [2:0]       r_active;
  logic [1:0]       r_vote;
  logic             r_error;
  logic             w_req;
  logic             w_valid;

  function automatic logic f_onehot3(input logic [2:0] v);
    f_onehot3 = (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Request decode and next-state logic
  always_comb begin
    w_req       = start_i & ~r_start;
    w_valid     = f_onehot3(master_core_i) & ~(safe_mode_i & safe_configuration_i[1]);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = w_valid ? S_HALT : S_ERROR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HALT: begin
        // All-parked wins over a timeout landing in the same cycle
        if (&core_sleep_i) begin
          w_state_nxt = S_SWITCH;
        end else if (r_cnt == HALT_LAST) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_state_nxt = S_HALT;
        end
      end
      S_SWITCH: w_state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (r_cnt == WAKE_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERROR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter, captured request and lockstep configuration registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= CNT_ZERO;
      r_start  <= 1'b0;
      r_mode   <= 1'b0;
      r_dmr    <= 1'b0;
      r_master <= 3'b001;
      r_active <= 3'b001;
      r_vote   <= 2'b00;
      r_error  <= 1'b0;
    end else begin
      r_start <= start_i;
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= CNT_ZERO;
      end else if ((r_state == S_HALT) || (r_state == S_RELEASE)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= CNT_ZERO;
      end
      if ((r_state == S_IDLE) && w_req) begin
        r_mode   <= safe_mode_i;
        r_dmr    <= safe_configuration_i[0];
        r_master <= master_core_i;
        r_error  <= 1'b0;
      end else if (r_state == S_ERROR) begin
        r_error  <= 1'b1;
      end else begin
        r_error  <= r_error;
      end
      if (r_state == S_SWITCH) begin
        if (!r_mode) begin
          r_active <= r_master;
          r_vote   <= 2'b00;
        end else if (r_dmr) begin
          r_active <= r_master | {r_master[1:0], r_master[2]};
          r_vote   <= 2'b01;
        end else begin
          r_active <= 3'b111;
          r_vote   <= 2'b10;
        end
      end
    end
  end

  assign debug_req_o    = (r_state == S_HALT)    ? 3'b111   : 3'b000;
  assign wake_o         = (r_state == S_RELEASE) ? r_active : 3'b000;
  assign active_cores_o = r_active;
  assign vote_mode_o    = r_vote;
  assign busy_o         = (r_state != S_IDLE);
  assign end_routine_o  = (r_state == S_DONE);
  assign error_o        = r_error;

endmodule

// File: tb/tb_safe_mode_sequencer.sv
// Directed self-checking bench for safe_mode_sequencer.
module tb_safe_mode_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       safe_mode_i = 1'b0;
  logic [1:0] safe_configuration_i = 2'b00;
  logic [2:0] master_core_i = 3'b001;
  logic [2:0] core_sleep_i = 3'b111;
  logic [2:0] debug_req_o;
  logic [2:0] wake_o;
  logic [2:0] active_cores_o;
  logic [1:0] vote_mode_o;
  logic       busy_o;
  logic       end_routine_o;
  logic       error_o;

  int n_cmp = 0;
  int n_err = 0;

  safe_mode_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .safe_mode_i(safe_mode_i),
    .safe_configuration_i(safe_configuration_i), .master_core_i(master_core_i),
    .core_sleep_i(core_sleep_i), .debug_req_o(debug_req_o), .wake_o(wake_o),
    .active_cores_o(active_cores_o), .vote_mode_o(vote_mode_o), .busy_o(busy_o),
    .end_routine_o(end_routine_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic request(input logic mode, input logic [1:0] cfg, input logic [2:0] master);
    safe_mode_i = mode;
    safe_configuration_i = cfg;
    master_core_i = master;
    start_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(); tick();
    n_cmp++; if (debug_req_o !== 3'b000) begin n_err++; $display("FAIL reset_debug: got %b want 000", debug_req_o); end
    n_cmp++; if (wake_o !== 3'b000) begin n_err++; $display("FAIL reset_wake: got %b want 000", wake_o); end
    n_cmp++; if (active_cores_o !== 3'b001) begin n_err++; $display("FAIL reset_active: got %b want 001", active_cores_o); end
    n_cmp++; if (vote_mode_o !== 2'b00) begin n_err++; $display("FAIL reset_vote: got %b want 00", vote_mode_o); end
    n_cmp++; if ({busy_o, end_routine_o, error_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy_o, end_routine_o, error_o}); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_tmr_entry();
    core_sleep_i = 3'b111;
    request(1'b1, 2'b00, 3'b001);
    tick(); // N+1 HALT
    n_cmp++; if (debug_req_o !== 3'b111) begin n_err++; $display("FAIL tmr_halt_debug: got %b want 111", debug_req_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL tmr_halt_busy: got %b want 1", busy_o); end
    tick(); // N+2 SWITCH
    n_cmp++; if (debug_req_o !== 3'b000) begin n_err++; $display("FAIL tmr_switch_debug: got %b want 000", debug_req_o); end
    n_cmp++; if (active_cores_o !== 3'b001) begin n_err++; $display("FAIL tmr_switch_active: got %b want 001", active_cores_o); end
    for (int i = 0; i < 4; i++) begin
      tick(); // N+3..N+6 RELEASE
      n_cmp++; if (wake_o !== 3'b111) begin n_err++; $display("FAIL tmr_wake[%0d]: got %b want 111", i, wake_o); end
      n_cmp++; if (end_routine_o !== 1'b0) begin n_err++; $display("FAIL tmr_end_early[%0d]: got %b want 0", i, end_routine_o); end
    end
    n_cmp++; if ({active_cores_o, vote_mode_o} !== 5'b111_10) begin n_err++; $display("FAIL tmr_config: got %b want 11110", {active_cores_o, vote_mode_o}); end
    tick(); // N+7 DONE
    n_cmp++; if (end_routine_o !== 1'b1) begin n_err++; $display("FAIL tmr_end: got %b want 1", end_routine_o); end
    n_cmp++; if (wake_o !== 3'b000) begin n_err++; $display("FAIL tmr_wake_off: got %b want 000", wake_o); end
    tick(); // N+8 IDLE
    n_cmp++; if ({busy_o, end_routine_o} !== 2'b00) begin n_err++; $display("FAIL tmr_idle: got %b want 00", {busy_o, end_routine_o}); end
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_dmr_entry_exit();
    int n;
    core_sleep_i = 3'b111;
    request(1'b1, 2'b01, 3'b100);
    n = 0;
    tick();
    while (end_routine_o !== 1'b1 && n < 30) begin tick(); n++; end
    n_cmp++; if (end_routine_o !== 1'b1) begin n_err++; $display("FAIL dmr_end_timeout: got %b want 1", end_routine_o); end
    n_cmp++; if ({active_cores_o, vote_mode_o} !== 5'b101_01) begin n_err++; $display("FAIL dmr_config: got %b want 10101", {active_cores_o, vote_mode_o}); end
    start_i = 1'b0;
    tick(); tick();
    request(1'b0, 2'b11, 3'b010);
    n = 0;
    tick();
    while (end_routine_o !== 1'b1 && n < 30) begin tick(); n++; end
    n_cmp++; if (end_routine_o !== 1'b1) begin n_err++; $display("FAIL exit_end_timeout: got %b want 1", end_routine_o); end
    n_cmp++; if ({active_cores_o, vote_mode_o} !== 5'b010_00) begin n_err++; $display("FAIL exit_config: got %b want 01000", {active_cores_o, vote_mode_o}); end
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL exit_error: got %b want 0", error_o); end
    start_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int cnt;
    logic saw_end;
    core_sleep_i = 3'b011;
    request(1'b1, 2'b00, 3'b001);
    tick(); // N+1 HALT
    cnt = 0;
    saw_end = 1'b0;
    while (debug_req_o === 3'b111 && cnt < 1100) begin
      cnt++;
      saw_end = saw_end | end_routine_o;
      tick();
    end
    n_cmp++; if (cnt !== 1024) begin n_err++; $display("FAIL timeout_halt_len: got %0d want 1024", cnt); end
    tick();
    n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL timeout_error: got %b want 1", error_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b want 0", busy_o); end
    n_cmp++; if ({active_cores_o, vote_mode_o} !== 5'b010_00) begin n_err++; $display("FAIL timeout_config: got %b want 01000", {active_cores_o, vote_mode_o}); end
    n_cmp++; if ((saw_end | end_routine_o) !== 1'b0) begin n_err++; $display("FAIL timeout_no_end: got %b want 0", saw_end | end_routine_o); end
    start_i = 1'b0;
    core_sleep_i = 3'b111;
    tick();
  endtask

  task automatic test_invalid();
    int n;
    request(1'b0, 2'b00, 3'b011);
    tick(); // N+1 ERROR; previous sticky error cleared on acceptance
    n_cmp++; if ({debug_req_o, busy_o, error_o} !== 5'b000_1_0) begin n_err++; $display("FAIL inv_master_n1: got %b want 00010", {debug_req_o, busy_o, error_o}); end
    tick(); // N+2
    n_cmp++; if ({debug_req_o, busy_o, error_o} !== 5'b000_0_1) begin n_err++; $display("FAIL inv_master_n2: got %b want 00001", {debug_req_o, busy_o, error_o}); end
    start_i = 1'b0;
    tick();
    request(1'b1, 2'b10, 3'b001);
    tick();
    n_cmp++; if ({debug_req_o, error_o} !== 4'b000_0) begin n_err++; $display("FAIL inv_cfg_n1: got %b want 0000", {debug_req_o, error_o}); end
    tick();
    n_cmp++; if ({debug_req_o, error_o} !== 4'b000_1) begin n_err++; $display("FAIL inv_cfg_n2: got %b want 0001", {debug_req_o, error_o}); end
    start_i = 1'b0;
    tick();
    request(1'b0, 2'b00, 3'b001);
    tick();
    n_cmp++; if ({debug_req_o, error_o} !== 4'b111_0) begin n_err++; $display("FAIL inv_clear: got %b want 1110", {debug_req_o, error_o}); end
    n = 0;
    while (end_routine_o !== 1'b1 && n < 30) begin tick(); n++; end
    n_cmp++; if ({end_routine_o, active_cores_o, vote_mode_o} !== 6'b1_001_00) begin n_err++; $display("FAIL inv_recover: got %b want 100100", {end_routine_o, active_cores_o, vote_mode_o}); end
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    core_sleep_i = 3'b000;
    request(1'b1, 2'b00, 3'b010);
    tick(); // N+1 HALT
    start_i = 1'b0;
    tick(); // N+2: second edge while in HALT
    start_i = 1'b1;
    tick();
    core_sleep_i = 3'b110; // one core still running: no switch yet
    tick();
    n_cmp++; if (debug_req_o !== 3'b111) begin n_err++; $display("FAIL b2b_still_halt: got %b want 111", debug_req_o); end
    core_sleep_i = 3'b111;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (end_routine_o === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    n_cmp++; if ({busy_o, active_cores_o, vote_mode_o} !== 6'b0_111_10) begin n_err++; $display("FAIL b2b_final: got %b want 011110", {busy_o, active_cores_o, vote_mode_o}); end
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_halt();
    int n;
    core_sleep_i = 3'b000;
    request(1'b1, 2'b01, 3'b001);
    tick();
    n_cmp++; if (debug_req_o !== 3'b111) begin n_err++; $display("FAIL rst_mid_halt: got %b want 111", debug_req_o); end
    rst_ni = 1'b0;
    start_i = 1'b0;
    tick();
    n_cmp++; if ({debug_req_o, wake_o, active_cores_o, vote_mode_o, busy_o, end_routine_o, error_o} !== 14'b000_000_001_00_000)
      begin n_err++; $display("FAIL rst_mid_outputs: got %b want 00000000100000", {debug_req_o, wake_o, active_cores_o, vote_mode_o, busy_o, end_routine_o, error_o}); end
    rst_ni = 1'b1;
    core_sleep_i = 3'b111;
    tick();
    request(1'b1, 2'b01, 3'b001);
    tick();
    n_cmp++; if (debug_req_o !== 3'b111) begin n_err++; $display("FAIL rst_new_edge: got %b want 111", debug_req_o); end
    n = 0;
    while (end_routine_o !== 1'b1 && n < 30) begin tick(); n++; end
    n_cmp++; if ({end_routine_o, active_cores_o, vote_mode_o} !== 6'b1_011_01) begin n_err++; $display("FAIL rst_new_seq: got %b want 101101", {end_routine_o, active_cores_o, vote_mode_o}); end
    start_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_tmr_entry();
    test_dmr_entry_exit();
    test_timeout();
    test_invalid();
    test_back_to_back();
    test_reset_mid_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
